// File: rtl/uart_rx_8n1.sv
// -----------------------------------------------------------------------------
// uart_rx_8n1
// Receive half of the serial console link. RXD is synchronised to CLK, start
// bits are found with 16x oversampling, and 8N1 frames (LSB first) are
// recovered. Each good byte is offered to the consumer on a valid/ready
// handshake.
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   RXD        asynchronous serial input, idle high
//   RX_DATA    received byte, stable while RX_VALID is high
//   RX_VALID   byte available, held until RX_VALID & RX_READY
//   RX_READY   consumer accepts the byte on a cycle with RX_VALID high
//   FRAME_ERR  one-cycle pulse: stop bit sampled low
//   OVERRUN    one-cycle pulse: good byte dropped because the previous byte
//              was still waiting
// -----------------------------------------------------------------------------
module uart_rx_8n1 #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200,
   parameter int DIV      = CLK_FREQ / (16 * BAUD)
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RXD,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   input  logic       RX_READY,
   output logic       FRAME_ERR,
   output logic       OVERRUN
);

   // A divisor below 1 would never tick; clamp it.
   localparam int            DIV_L     = (DIV < 1) ? 1 : DIV;
   localparam int            TW        = (DIV_L > 1) ? $clog2(DIV_L) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV_L - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   // Two-of-three majority of the samples around mid-bit.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   state_t          state_r;
   state_t          state_n_s;
   logic            sync1_r;
   logic            rxs_r;
   logic [TW-1:0]   tcnt_r;
   logic [3:0]      scnt_r;
   logic [2:0]      bcnt_r;
   logic            v7_r;
   logic            v8_r;
   logic [7:0]      shift_r;
   logic [7:0]      rx_data_r;
   logic            rx_valid_r;
   logic            frame_err_r;
   logic            overrun_r;

   logic            tick_s;
   logic            vote_pt_s;
   logic            wrap_s;
   logic            vote_s;
   logic            clr_s;
   logic            shift_s;
   logic            bcnt_inc_s;
   logic            commit_s;
   logic            ferr_s;

   assign tick_s    = (tcnt_r == TICK_LAST);
   // scnt_r is the count before this tick, so the three samples land as scnt
   // reaches 7, 8 and 9; the decision is taken as it reaches 9 (9/16 into
   // the bit) using the live synchronised input as the third sample.
   assign vote_pt_s = tick_s && (scnt_r == 4'd8);
   assign wrap_s    = tick_s && (scnt_r == 4'd15);
   assign vote_s    = maj3(v7_r, v8_r, rxs_r);

   // Next-state and control strobes for the frame FSM.
   always_comb begin
      state_n_s  = state_r;
      clr_s      = 1'b0;
      shift_s    = 1'b0;
      bcnt_inc_s = 1'b0;
      commit_s   = 1'b0;
      ferr_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!rxs_r) begin
               state_n_s = ST_START;
               clr_s     = 1'b1;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (vote_pt_s && vote_s) begin
               state_n_s = ST_IDLE;      // line went back high: glitch
            end else if (wrap_s) begin
               state_n_s = ST_DATA;
            end else begin
               state_n_s = ST_START;
            end
         end
         ST_DATA: begin
            shift_s = vote_pt_s;
            if (wrap_s) begin
               bcnt_inc_s = 1'b1;
               if (bcnt_r == 3'd7) begin
                  state_n_s = ST_STOP;
               end else begin
                  state_n_s = ST_DATA;
               end
            end else begin
               state_n_s = ST_DATA;
            end
         end
         ST_STOP: begin
            // Leaving at mid stop bit lets a back-to-back start edge be seen.
            if (vote_pt_s) begin
               if (vote_s) begin
                  commit_s  = 1'b1;
                  state_n_s = ST_IDLE;
               end else begin
                  ferr_s    = 1'b1;
                  state_n_s = ST_BREAK;
               end
            end else begin
               state_n_s = ST_STOP;
            end
         end
         ST_BREAK: begin
            // A held-low line must return high before another start is taken.
            if (rxs_r) begin
               state_n_s = ST_IDLE;
            end else begin
               state_n_s = ST_BREAK;
            end
         end
         default: begin
            state_n_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Two-flop synchroniser for the asynchronous RXD pin, idle-high reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_r <= 1'b1;
         rxs_r   <= 1'b1;
      end else begin
         sync1_r <= RXD;
         rxs_r   <= sync1_r;
      end
   end

   // Oversample tick divider, restarted on the start edge so samples are
   // phased to the detected edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         tcnt_r <= '0;
      end else if (clr_s || tick_s) begin
         tcnt_r <= '0;
      end else begin
         tcnt_r <= tcnt_r + TW'(1);
      end
   end

   // Sample counter within a bit and data bit counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         scnt_r <= 4'd0;
         bcnt_r <= 3'd0;
      end else begin
         if (clr_s) begin
            scnt_r <= 4'd0;
         end else if (tick_s) begin
            scnt_r <= scnt_r + 4'd1;
         end else begin
            scnt_r <= scnt_r;
         end
         if (clr_s) begin
            bcnt_r <= 3'd0;
         end else if (bcnt_inc_s) begin
            bcnt_r <= bcnt_r + 3'd1;
         end else begin
            bcnt_r <= bcnt_r;
         end
      end
   end

   // Early vote samples and the LSB-first data shift register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         v7_r    <= 1'b0;
         v8_r    <= 1'b0;
         shift_r <= 8'h00;
      end else begin
         if (tick_s && (scnt_r == 4'd6)) begin
            v7_r <= rxs_r;
         end
         if (tick_s && (scnt_r == 4'd7)) begin
            v8_r <= rxs_r;
         end
         if (shift_s) begin
            shift_r <= {vote_s, shift_r[7:1]};
         end
      end
   end

   // Output holding register, handshake and event pulses.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_data_r   <= 8'h00;
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         frame_err_r <= ferr_s;
         overrun_r   <= commit_s && rx_valid_r && !RX_READY;
         if (commit_s && (!rx_valid_r || RX_READY)) begin
            // Slot is free, or is being emptied this very cycle.
            rx_data_r  <= shift_r;
            rx_valid_r <= 1'b1;
         end else if (rx_valid_r && RX_READY) begin
            rx_valid_r <= 1'b0;
         end
      end
   end

   assign RX_DATA   = rx_data_r;
   assign RX_VALID  = rx_valid_r;
   assign FRAME_ERR = frame_err_r;
   assign OVERRUN   = overrun_r;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_8n1
// Directed and randomised frames driven onto RXD by a bit-level transmitter.
// A negedge monitor records handshakes and event pulses; the bench keeps its
// own queue of bytes that should be delivered and compares against it.
// -----------------------------------------------------------------------------
module tb_uart_rx_8n1;

   localparam int CLK_FREQ = 50000000;
   localparam int BAUD     = 115200;
   localparam int DIV_EXP  = CLK_FREQ / (16 * BAUD);
   localparam int BIT      = 16 * DIV_EXP;

   logic       CLK      = 1'b0;
   logic       RST      = 1'b1;
   logic       RXD      = 1'b1;
   logic       RX_READY = 1'b0;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic       FRAME_ERR;
   logic       OVERRUN;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int fall_cyc = 0;

   uart_rx_8n1 #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RXD       (RXD),
      .RX_DATA   (RX_DATA),
      .RX_VALID  (RX_VALID),
      .RX_READY  (RX_READY),
      .FRAME_ERR (FRAME_ERR),
      .OVERRUN   (OVERRUN)
   );

   always #10 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: sampled on the falling edge, away from DUT updates.
   logic valid_q = 1'b0;
   logic fe_q    = 1'b0;
   logic ov_q    = 1'b0;
   int valid_rises = 0, valid_hi = 0, fe_pulses = 0, fe_hi = 0;
   int ov_pulses = 0, ov_hi = 0, rise_cyc = 0, ov_cyc = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   always @(negedge CLK) begin
      if (RX_VALID && !valid_q) begin
         valid_rises <= valid_rises + 1;
         rise_cyc    <= cyc;
      end
      if (RX_VALID) valid_hi <= valid_hi + 1;
      if (RX_VALID && RX_READY) got_q.push_back(RX_DATA);
      if (FRAME_ERR) fe_hi <= fe_hi + 1;
      if (FRAME_ERR && !fe_q) fe_pulses <= fe_pulses + 1;
      if (OVERRUN) ov_hi <= ov_hi + 1;
      if (OVERRUN && !ov_q) begin
         ov_pulses <= ov_pulses + 1;
         ov_cyc    <= cyc;
      end
      valid_q <= RX_VALID;
      fe_q    <= FRAME_ERR;
      ov_q    <= OVERRUN;
   end

   int vr0, vh0, fp0, fh0, op0, oh0, lat;

   task automatic snap();
      vr0 = valid_rises; vh0 = valid_hi; fp0 = fe_pulses;
      fh0 = fe_hi;       op0 = ov_pulses; oh0 = ov_hi;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic check_q(input string tag);
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) chk({tag, "_byte"}, int'(got_q[i]), int'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic idle(input int n);
      RXD = 1'b1;
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   // Drives one 8N1 frame; rst_at >= 0 pulses RST at that cycle of the frame,
   // abandons the rest of the frame and checks the cleared outputs.
   task automatic tx_frame(input logic [7:0] b, input logic stop_b,
                           input int bit_clks, input int rst_at);
      logic [9:0] fr;
      bit aborted;
      fr = {stop_b, b, 1'b0};
      aborted = 1'b0;
      fall_cyc = cyc;
      for (int i = 0; i < 10 * bit_clks; i++) begin
         if (i == rst_at) begin
            RST = 1'b1;
            aborted = 1'b1;
         end else begin
            RST = 1'b0;
         end
         if (aborted) RXD = 1'b1;
         else         RXD = fr[i / bit_clks];
         if (rst_at >= 0 && i == rst_at + 1) begin
            chk("rst_mid_valid", int'(RX_VALID), 0);
            chk("rst_mid_data", int'(RX_DATA), 0);
            chk("rst_mid_ferr", int'(FRAME_ERR), 0);
            chk("rst_mid_ovr", int'(OVERRUN), 0);
         end
         @(posedge CLK); #1;
      end
      RST = 1'b0;
      RXD = 1'b1;
   endtask

   initial begin
      logic [7:0] rb;

      // Reset state.
      RST = 1'b1;
      repeat (4) begin @(posedge CLK); #1; end
      chk("reset_valid", int'(RX_VALID), 0);
      chk("reset_data", int'(RX_DATA), 0);
      chk("reset_ferr", int'(FRAME_ERR), 0);
      chk("reset_ovr", int'(OVERRUN), 0);
      RST = 1'b0;
      idle(20);

      // Single byte, consumer not ready.
      RX_READY = 1'b0;
      snap();
      tx_frame(8'h55, 1'b1, BIT, -1);
      idle(200);
      chk("single_rises", valid_rises - vr0, 1);
      chk_rng("single_latency", rise_cyc - fall_cyc, 4120, 4150);
      chk("single_data", int'(RX_DATA), 'h55);
      chk("single_held", int'(RX_VALID), 1);
      RX_READY = 1'b1;
      @(posedge CLK); #1;
      RX_READY = 1'b0;
      chk("single_accept_clear", int'(RX_VALID), 0);
      exp_q.push_back(8'h55);
      check_q("single");

      // Back-to-back stream with consumer always ready.
      RX_READY = 1'b1;
      snap();
      tx_frame(8'hA3, 1'b1, BIT, -1); exp_q.push_back(8'hA3);
      tx_frame(8'h00, 1'b1, BIT, -1); exp_q.push_back(8'h00);
      tx_frame(8'hFF, 1'b1, BIT, -1); exp_q.push_back(8'hFF);
      idle(100);
      chk("stream_rises", valid_rises - vr0, 3);
      chk("stream_valid_cycles", valid_hi - vh0, 3);
      chk("stream_ferr", fe_pulses - fp0, 0);
      chk("stream_ovr", ov_pulses - op0, 0);
      check_q("stream");

      // Framing error followed by a long low line, then a good byte.
      snap();
      tx_frame(8'h3C, 1'b0, BIT, -1);
      RXD = 1'b0;
      repeat (2 * BIT) begin @(posedge CLK); #1; end
      idle(BIT);
      chk("ferr_pulses", fe_pulses - fp0, 1);
      chk("ferr_width", fe_hi - fh0, 1);
      chk("ferr_no_valid", valid_rises - vr0, 0);
      tx_frame(8'h81, 1'b1, BIT, -1); exp_q.push_back(8'h81);
      idle(100);
      chk("ferr_recover_rises", valid_rises - vr0, 1);
      check_q("ferr_recover");

      // Short glitch is rejected.
      snap();
      RXD = 1'b0;
      repeat (100) begin @(posedge CLK); #1; end
      idle(1000);
      chk("glitch_no_valid", valid_rises - vr0, 0);
      chk("glitch_no_ferr", fe_pulses - fp0, 0);

      // Random bytes after the glitch.
      snap();
      for (int k = 0; k < 2; k++) begin
         rb = 8'($urandom_range(0, 255));
         tx_frame(rb, 1'b1, BIT, -1);
         exp_q.push_back(rb);
      end
      idle(100);
      chk("rand_ferr", fe_pulses - fp0, 0);
      chk("rand_ovr", ov_pulses - op0, 0);
      check_q("rand");

      // Overrun: second byte dropped while the first waits.
      RX_READY = 1'b0;
      idle(10);
      snap();
      tx_frame(8'h12, 1'b1, BIT, -1);
      lat = rise_cyc - fall_cyc;
      tx_frame(8'h34, 1'b1, BIT, -1);
      idle(50);
      chk("ovr_data_kept", int'(RX_DATA), 'h12);
      chk("ovr_valid", int'(RX_VALID), 1);
      chk("ovr_pulses", ov_pulses - op0, 1);
      chk("ovr_width", ov_hi - oh0, 1);
      chk("ovr_at_commit", ov_cyc - fall_cyc, lat);

      // Commit on the same cycle as acceptance of the waiting byte.
      snap();
      fork
         tx_frame(8'h34, 1'b1, BIT, -1);
         begin
            repeat (lat - 1) @(posedge CLK);
            #1 RX_READY = 1'b1;
            @(posedge CLK);
            #1 RX_READY = 1'b0;
         end
      join
      idle(50);
      exp_q.push_back(8'h12);
      chk("coinc_data", int'(RX_DATA), 'h34);
      chk("coinc_valid", int'(RX_VALID), 1);
      chk("coinc_no_ovr", ov_pulses - op0, 0);
      check_q("coinc");

      // Reset during data bits, then skewed-rate frames.
      snap();
      tx_frame(8'h9A, 1'b1, BIT, 4 * BIT + 100);
      idle(BIT);
      chk("rst_no_frame", valid_rises - vr0, 0);
      RX_READY = 1'b1;
      tx_frame(8'hC6, 1'b1, (BIT * 100) / 103, -1); exp_q.push_back(8'hC6);
      idle(200);
      tx_frame(8'hC6, 1'b1, (BIT * 100) / 97, -1);  exp_q.push_back(8'hC6);
      idle(200);
      chk("skew_ferr", fe_pulses - fp0, 0);
      check_q("skew");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Receive-side UART for the board's serial console link. It takes the asynchronous RXD pin, synchronises it to the system clock, and detects start bits with 16x oversampling. It recovers 8N1 frames, LSB first, and presents each byte on a valid/ready interface to the consuming logic (PWM command parser or Nios bridge). It is the counterpart of the existing UART transmit path.

## Interface

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- DIV, CLK_FREQ/(16*BAUD): oversample tick divisor. Integer truncation is used (27 at defaults). Values below 1 are forced to 1.

Ports:
- CLK  in  1  system clock; all logic runs on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- RXD  in  1  serial input, asynchronous, idle high.
- RX_DATA  out  8  received byte; stable while RX_VALID=1.
- RX_VALID  out  1  byte available; held until accepted.
- RX_READY  in  1  consumer accepts the byte on a cycle where RX_VALID=1 and RX_READY=1.
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  out  1  one-cycle pulse: a good byte was completed while the previous byte was still unaccepted.

## Operation

- Input synchroniser: two flops, reset value 1. All decisions use the second flop (rxs).
- Tick generator: counts 0..DIV-1 and emits a one-cycle tick at DIV-1. It is cleared on entry to START.
- A sample counter scnt (0..15) advances on each tick. A bit counter bcnt (0..7) counts data bits.
- Majority vote: the bit value is the majority of rxs at scnt = 7, 8 and 9.
- States:
  - IDLE: rxs=0 moves to START, and clears the tick counter, scnt and bcnt.
  - START: at scnt=9, a vote of 1 is a false start and returns to IDLE. A vote of 0 waits for scnt wrap to 15→0, then moves to DATA.
  - DATA: at scnt=9, the vote is shifted in at bit 7 (right shift, so LSB ends in bit 0). At wrap, bcnt increments. At wrap with bcnt=7, the state moves to STOP.
  - STOP: at scnt=9, a vote of 1 commits the byte and moves to IDLE. A vote of 0 pulses FRAME_ERR, discards the byte and moves to BREAK.
  - BREAK: waits for rxs=1, then moves to IDLE. This keeps a held-low line from producing repeated frames.
- Commit:
  - If RX_VALID=0, or RX_VALID=1 with RX_READY=1 in the commit cycle: load RX_DATA and set RX_VALID=1.
  - Else: keep the old RX_DATA and RX_VALID, drop the new byte, and pulse OVERRUN.
- Acceptance: RX_VALID=1 with RX_READY=1 clears RX_VALID on the next edge, unless a commit happens in the same cycle.
- Reset: state IDLE, counters 0, shift register 0. Outputs: RX_DATA=0x00, RX_VALID=0, FRAME_ERR=0, OVERRUN=0.
- Reset mid-frame aborts the frame with no output event.

## Timing

- Bit period: 16*DIV clocks (432 at defaults, actual rate 115741 bit/s, +0.47%).
- Latency: from the RXD falling edge to RX_VALID rising is 2 sync cycles + (16*9 + 9)*DIV + ~2 cycles. This is about 4133 cycles at defaults, with the stop bit sampled 9/16 into the bit.
- RX_VALID rises one cycle after the stop-bit vote. FRAME_ERR and OVERRUN pulse in that same cycle, for exactly one cycle.
- Back-to-back frames (stop bit followed immediately by a start bit) are received without loss. IDLE is re-entered before the stop bit ends.
- Tolerance: correct reception at ±3% baud mismatch between transmitter and DIV.
- RX_READY may be held permanently high. The byte is then visible for exactly one cycle.

## Test plan

- Single byte: 0x55 at 115200, RX_READY=0 → RX_VALID=1 and RX_DATA=0x55 about 4133 cycles after the edge, held until RX_READY pulse. RX_VALID falls the cycle after acceptance.
- Stream with RX_READY=1: 0xA3, 0x00, 0xFF back-to-back → three one-cycle RX_VALID pulses with matching data, no FRAME_ERR or OVERRUN.
- Framing error: 0x3C with stop bit driven 0, line held low 2 bit times → one FRAME_ERR pulse, no RX_VALID. A following 0x81 is received correctly after the line returns high.
- Glitch: RXD low for 100 cycles (under half a bit) → no RX_VALID, no FRAME_ERR, state back in IDLE.
- Overrun: 0x12 then 0x34 with RX_READY=0 → RX_DATA stays 0x12 and OVERRUN pulses once at the second commit. Commit coinciding with acceptance → 0x34 loaded, no OVERRUN.
- Reset and skew: RST asserted mid data bits → all outputs 0 next cycle and the next frame decodes. Frames 0xC6 at BAUD*1.03 and BAUD*0.97 → decoded correctly.
